// File: rtl/upcounter_4_bit.sv
// Presettable, loadable modulo counter with a 4-bit registered count.
// The count runs 0..mod_max and then wraps to 0. Each wrap event raises a
// one-cycle registered carry pulse (co) and bumps a saturating wrap counter.
// tc is a purely combinational look-ahead flag: "the next enabled edge wraps".
module upcounter_4_bit #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              clr_bar,
    input  logic              pre_bar,
    input  logic              load_bar,
    input  logic              D0,
    input  logic              D1,
    input  logic              D2,
    input  logic              D3,
    input  logic              en,
    input  logic [3:0]        mod_max,
    output logic              Q0,
    output logic              Q1,
    output logic              Q2,
    output logic              Q3,
    output logic              Q0_bar,
    output logic              Q1_bar,
    output logic              Q2_bar,
    output logic              Q3_bar,
    output logic              tc,
    output logic              co,
    output logic [WRAP_W-1:0] wraps
);

    // Operating modes resolved from the control inputs, highest priority first.
    typedef enum logic [1:0] {
        MODE_PRESET = 2'd0,
        MODE_LOAD   = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_t;

    logic [3:0]        q_reg;
    logic [3:0]        q_next;
    logic              co_reg;
    logic              co_next;
    logic [WRAP_W-1:0] wraps_reg;
    logic [WRAP_W-1:0] wraps_next;

    logic [3:0]        load_data;
    logic              at_terminal;
    logic              wraps_full;
    mode_t             mode;

    assign load_data   = {D3, D2, D1, D0};
    // ">=" rather than "==": a count parked above mod_max (after a load or a
    // mod_max change) must wrap on the next enabled edge instead of running on.
    assign at_terminal = (q_reg >= mod_max);
    assign wraps_full  = &wraps_reg;

    // Decode the control inputs into a single mode (clear is handled in the register).
    always_comb begin
        mode = MODE_HOLD;
        if (!pre_bar) begin
            mode = MODE_PRESET;
        end else if (!load_bar) begin
            mode = MODE_LOAD;
        end else if (en) begin
            mode = MODE_COUNT;
        end
    end

    // Next count, carry and wrap tally for the selected mode.
    always_comb begin
        q_next     = q_reg;
        co_next    = 1'b0;
        wraps_next = wraps_reg;
        case (mode)
            MODE_PRESET: begin
                q_next = mod_max;
            end
            MODE_LOAD: begin
                q_next = load_data;
            end
            MODE_COUNT: begin
                if (at_terminal) begin
                    q_next  = 4'd0;
                    co_next = 1'b1;
                    if (!wraps_full) begin
                        wraps_next = wraps_reg + WRAP_W'(1);
                    end
                end else begin
                    q_next = q_reg + 4'd1;
                end
            end
            default: begin
                q_next = q_reg;
            end
        endcase
    end

    // State registers with synchronous active-low clear overriding every other control.
    always_ff @(posedge clk) begin
        if (!clr_bar) begin
            q_reg     <= 4'd0;
            co_reg    <= 1'b0;
            wraps_reg <= '0;
        end else begin
            q_reg     <= q_next;
            co_reg    <= co_next;
            wraps_reg <= wraps_next;
        end
    end

    // Bit-level outputs; the complements are derived directly from the register.
    assign {Q3, Q2, Q1, Q0}                 = q_reg;
    assign {Q3_bar, Q2_bar, Q1_bar, Q0_bar} = ~q_reg;

    // tc ignores clear/preset/load on purpose: it only reflects enable and count.
    assign tc    = en & at_terminal;
    assign co    = co_reg;
    assign wraps = wraps_reg;

endmodule

// File: tb/tb_upcounter_4_bit.sv
// Directed testbench for upcounter_4_bit. A second instance with a 2-bit wrap
// counter shares all inputs and is used for the saturation scenario.
`timescale 1ns/1ps
module tb_upcounter_4_bit;

    logic       clk = 1'b0;
    logic       clr_bar = 1'b1, pre_bar = 1'b1, load_bar = 1'b1, en = 1'b0;
    logic       D0 = 1'b0, D1 = 1'b0, D2 = 1'b0, D3 = 1'b0;
    logic [3:0] mod_max = 4'd15;

    logic       Q0, Q1, Q2, Q3, Q0_bar, Q1_bar, Q2_bar, Q3_bar, tc, co;
    logic [7:0] wraps;
    logic       s_Q0, s_Q1, s_Q2, s_Q3, s_Q0_bar, s_Q1_bar, s_Q2_bar, s_Q3_bar, s_tc, s_co;
    logic [1:0] s_wraps;

    logic [3:0] q, qb, s_q;
    assign q   = {Q3, Q2, Q1, Q0};
    assign qb  = {Q3_bar, Q2_bar, Q1_bar, Q0_bar};
    assign s_q = {s_Q3, s_Q2, s_Q1, s_Q0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    upcounter_4_bit #(.WRAP_W(8)) dut (
        .clk(clk), .clr_bar(clr_bar), .pre_bar(pre_bar), .load_bar(load_bar),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3), .en(en), .mod_max(mod_max),
        .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
        .Q0_bar(Q0_bar), .Q1_bar(Q1_bar), .Q2_bar(Q2_bar), .Q3_bar(Q3_bar),
        .tc(tc), .co(co), .wraps(wraps)
    );

    upcounter_4_bit #(.WRAP_W(2)) dut_sat (
        .clk(clk), .clr_bar(clr_bar), .pre_bar(pre_bar), .load_bar(load_bar),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3), .en(en), .mod_max(mod_max),
        .Q0(s_Q0), .Q1(s_Q1), .Q2(s_Q2), .Q3(s_Q3),
        .Q0_bar(s_Q0_bar), .Q1_bar(s_Q1_bar), .Q2_bar(s_Q2_bar), .Q3_bar(s_Q3_bar),
        .tc(s_tc), .co(s_co), .wraps(s_wraps)
    );

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] v);
        {D3, D2, D1, D0} = v;
    endtask

    task automatic test_reset();
        clr_bar = 1'b0; pre_bar = 1'b0; load_bar = 1'b0; en = 1'b1;
        mod_max = 4'd15; set_d(4'b1010);
        tick();
        tick();
        checks++;
        if (q !== 4'd0 || co !== 1'b0 || wraps !== 8'd0) begin
            errors++;
            $display("FAIL reset: q=%0d co=%b wraps=%0d, required q=0 co=0 wraps=0", q, co, wraps);
        end
        checks++;
        if (qb !== 4'hF) begin
            errors++;
            $display("FAIL reset_qbar: qbar=%b, required 1111", qb);
        end
        pre_bar = 1'b1; load_bar = 1'b1;
        #1;
        $display("reset: q=%0d co=%b wraps=%0d", q, co, wraps);
    endtask

    task automatic test_count_full();
        logic [3:0] exp_q;
        clr_bar = 1'b1; en = 1'b1; mod_max = 4'd15;
        #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL full_tc_start: tc=%b, required 0", tc);
        end
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_q = 4'(k % 16);
            checks++;
            if (q !== exp_q || qb !== ~exp_q || tc !== (exp_q == 4'd15) || co !== (k == 16)) begin
                errors++;
                $display("FAIL full_count step %0d: q=%0d qbar=%b tc=%b co=%b, required q=%0d tc=%b co=%b",
                         k, q, qb, tc, co, exp_q, (exp_q == 4'd15), (k == 16));
            end
            $display("full_count step %0d: q=%0d tc=%b co=%b", k, q, tc, co);
        end
        checks++;
        if (wraps !== 8'd1) begin
            errors++;
            $display("FAIL full_wraps: wraps=%0d, required 1", wraps);
        end
    endtask

    task automatic test_mod6();
        logic [3:0] exp_q;
        clr_bar = 1'b0;
        tick();
        clr_bar = 1'b1; mod_max = 4'd5; en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_q = 4'(k % 6);
            checks++;
            if (q !== exp_q || tc !== (exp_q == 4'd5) || co !== ((k % 6) == 0)) begin
                errors++;
                $display("FAIL mod6 step %0d: q=%0d tc=%b co=%b, required q=%0d tc=%b co=%b",
                         k, q, tc, co, exp_q, (exp_q == 4'd5), ((k % 6) == 0));
            end
            $display("mod6 step %0d: q=%0d co=%b", k, q, co);
        end
        checks++;
        if (wraps !== 8'd2) begin
            errors++;
            $display("FAIL mod6_wraps: wraps=%0d, required 2", wraps);
        end
    endtask

    task automatic test_preset_load();
        // Previous edge was a wrap, so co is high entering this test.
        pre_bar = 1'b0; mod_max = 4'd9;
        tick();
        checks++;
        if (q !== 4'd9 || co !== 1'b0 || wraps !== 8'd2) begin
            errors++;
            $display("FAIL preset: q=%0d co=%b wraps=%0d, required q=9 co=0 wraps=2", q, co, wraps);
        end
        $display("preset: q=%0d co=%b", q, co);
        pre_bar = 1'b1; load_bar = 1'b0; set_d(4'b1100);
        tick();
        checks++;
        if (q !== 4'd12 || co !== 1'b0) begin
            errors++;
            $display("FAIL load: q=%0d co=%b, required q=12 co=0", q, co);
        end
        $display("load: q=%0d co=%b", q, co);
        load_bar = 1'b1;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL load_tc: tc=%b, required 1", tc);
        end
        tick();
        checks++;
        if (q !== 4'd0 || co !== 1'b1 || wraps !== 8'd3) begin
            errors++;
            $display("FAIL over_wrap: q=%0d co=%b wraps=%0d, required q=0 co=1 wraps=3", q, co, wraps);
        end
        $display("over_wrap: q=%0d co=%b wraps=%0d", q, co, wraps);
    endtask

    task automatic test_simultaneous();
        clr_bar = 1'b0; pre_bar = 1'b0; load_bar = 1'b0; set_d(4'b0011);
        tick();
        checks++;
        if (q !== 4'd0 || co !== 1'b0 || wraps !== 8'd0) begin
            errors++;
            $display("FAIL clr_priority: q=%0d co=%b wraps=%0d, required 0 0 0", q, co, wraps);
        end
        clr_bar = 1'b1; mod_max = 4'd6;
        tick();
        checks++;
        if (q !== 4'd6) begin
            errors++;
            $display("FAIL pre_priority: q=%0d, required 6", q);
        end
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL tc_ignores_ctrl: tc=%b, required 1", tc);
        end
        $display("simultaneous: q=%0d tc=%b", q, tc);
        pre_bar = 1'b1; load_bar = 1'b1;
    endtask

    task automatic test_hold_glitch();
        load_bar = 1'b0; set_d(4'b0111); mod_max = 4'd15; en = 1'b1;
        tick();
        load_bar = 1'b0;
        load_bar = 1'b1; en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (q !== 4'd7 || tc !== 1'b0 || co !== 1'b0) begin
                errors++;
                $display("FAIL hold step %0d: q=%0d tc=%b co=%b, required q=7 tc=0 co=0", k, q, tc, co);
            end
            $display("hold step %0d: q=%0d", k, q);
        end
        en = 1'b1;
        #2 clr_bar = 1'b0;
        #2 clr_bar = 1'b1;
        tick();
        checks++;
        if (q !== 4'd8) begin
            errors++;
            $display("FAIL glitch: q=%0d, required 8", q);
        end
        $display("glitch: q=%0d", q);
    endtask

    task automatic test_back_to_back();
        // q=8 with mod_max=8: the coming edge would wrap, but clear wins.
        mod_max = 4'd8;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL abort_tc: tc=%b, required 1", tc);
        end
        clr_bar = 1'b0;
        tick();
        checks++;
        if (q !== 4'd0 || co !== 1'b0) begin
            errors++;
            $display("FAIL abort_carry: q=%0d co=%b, required q=0 co=0", q, co);
        end
        clr_bar = 1'b1;
        tick();
        checks++;
        if (q !== 4'd1 || co !== 1'b0 || wraps !== 8'd0) begin
            errors++;
            $display("FAIL resume: q=%0d co=%b wraps=%0d, required q=1 co=0 wraps=0", q, co, wraps);
        end
        $display("back_to_back: q=%0d co=%b", q, co);
    endtask

    task automatic test_saturation();
        logic [1:0] exp_w;
        clr_bar = 1'b0;
        tick();
        clr_bar = 1'b1; mod_max = 4'd0; en = 1'b1;
        #1;
        checks++;
        if (s_wraps !== 2'd0 || s_tc !== 1'b1) begin
            errors++;
            $display("FAIL sat_start: wraps=%0d tc=%b, required wraps=0 tc=1", s_wraps, s_tc);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_w = (k >= 3) ? 2'd3 : 2'(k);
            checks++;
            if (s_wraps !== exp_w || s_co !== 1'b1 || s_q !== 4'd0) begin
                errors++;
                $display("FAIL saturation step %0d: wraps=%0d co=%b q=%0d, required wraps=%0d co=1 q=0",
                         k, s_wraps, s_co, s_q, exp_w);
            end
            $display("saturation step %0d: wraps=%0d co=%b", k, s_wraps, s_co);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_count_full();
        test_mod6();
        test_preset_load();
        test_simultaneous();
        test_hold_glitch();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
